// File: rtl/dbg_pkg.sv
// Shared definitions for the debug command engine: command bytes, FSM states,
// CRC constants and the CRC-8 step function.
package dbg_pkg;

  localparam logic [7:0] CmdSetCount = 8'h82;
  localparam logic [7:0] CmdSetAddr  = 8'h83;
  localparam logic [7:0] CmdRead     = 8'h84;
  localparam logic [7:0] CmdWrite    = 8'h85;
  localparam logic [7:0] CmdAlive    = 8'h86;
  localparam logic [7:0] CmdCoreRst  = 8'h87;
  localparam logic [7:0] CmdCoreNorm = 8'h88;

  localparam logic [7:0] CRC_INIT = 8'h00;
  localparam logic [7:0] ALIVE_HI = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StArg,
    StBusWr,
    StBusRd,
    StTxWord,
    StTxAck
  } state_e;

  // CRC-8, MSB first, no reflection: fold one byte into the running value.
  function automatic logic [7:0] crc8_update(logic [7:0] crc, logic [7:0] data,
                                             logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dbg_crc8.sv
// Combinational CRC-8 next-value: crc_o = crc_i with data_i folded in.
module dbg_crc8
  import dbg_pkg::*;
#(
  parameter logic [7:0] Poly = 8'h07
) (
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  assign crc_o = crc8_update(crc_i, data_i, Poly);

endmodule

// File: rtl/dbg_cmd_engine.sv
// Debug command engine: parses debugger bytes from the UART, issues 32-bit bus
// reads/writes, returns response bytes and drives the core hold-in-reset line.
// Build option: define DBG_CRC_EN to append a CRC-8 acknowledge byte to
// SET_COUNT / SET_ADDR / WRITE / READ; without it those commands stay silent
// (READ still returns its data bytes).
module dbg_cmd_engine
  import dbg_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [7:0]  ALIVE_BYTE = 8'hAE,
  parameter logic [7:0]  CRC_POLY   = 8'h07
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              bus_req,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_done,
  output logic              core_rst_o,
  output logic              rx_overrun
);

  state_e              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         asm_q, asm_d, asm_next;
  logic [7:0]          count_q, count_d;
  logic [7:0]          words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          tx_rem_q, tx_rem_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                core_rst_q, core_rst_d;
  logic                overrun_q, overrun_d;

`ifdef DBG_CRC_EN
  localparam bit CrcEn = 1'b1;
  logic [7:0] crc_q, crc_d, crc_in, crc_next;

  dbg_crc8 #(
    .Poly(CRC_POLY)
  ) u_crc (
    .crc_i (crc_q),
    .data_i(crc_in),
    .crc_o (crc_next)
  );

  // CRC covers received argument bytes, or transmitted bytes while in TX_WORD.
  always_comb begin
    crc_in = (state_q == StTxWord) ? tx_data_q : rx_data;
    crc_d  = crc_q;
    if (state_q == StIdle && rx_valid) begin
      crc_d = CRC_INIT;
    end else if (state_q == StArg && rx_valid) begin
      crc_d = crc_next;
    end else if (state_q == StTxWord && tx_ready) begin
      crc_d = crc_next;
    end
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end
`else
  localparam bit CrcEn = 1'b0;
  logic [7:0] crc_q, crc_next;
  assign crc_q    = CRC_INIT;
  assign crc_next = CRC_INIT;
`endif

  // Byte assembly: argument bytes arrive MSB first.
  assign asm_next = {asm_q[23:0], rx_data};

  // Next-state and datapath updates for the command FSM.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    count_d    = count_q;
    words_d    = words_q;
    addr_d     = addr_q;
    word_d     = word_q;
    tx_rem_d   = tx_rem_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    core_rst_d = core_rst_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          cmd_d = rx_data;
          idx_d = 2'd0;
          case (rx_data)
            CmdSetCount, CmdSetAddr: state_d = StArg;
            CmdRead: begin
              if (count_q == 8'd0) begin
                if (CrcEn) begin
                  state_d    = StTxAck;
                  tx_valid_d = 1'b1;
                  tx_data_d  = CRC_INIT;
                end
              end else begin
                words_d = count_q;
                state_d = StBusRd;
              end
            end
            CmdWrite: begin
              if (count_q == 8'd0) begin
                if (CrcEn) begin
                  state_d    = StTxAck;
                  tx_valid_d = 1'b1;
                  tx_data_d  = CRC_INIT;
                end
              end else begin
                words_d = count_q;
                state_d = StArg;
              end
            end
            CmdAlive: begin
              state_d    = StTxWord;
              tx_valid_d = 1'b1;
              tx_data_d  = ALIVE_HI;
              word_d     = {ALIVE_HI, ALIVE_BYTE, 16'h0000};
              tx_rem_d   = 2'd1;
            end
            CmdCoreRst:  core_rst_d = 1'b1;
            CmdCoreNorm: core_rst_d = 1'b0;
            default: ;
          endcase
        end
      end

      StArg: begin
        // Every byte here is data, even with bit7 set.
        if (rx_valid) begin
          asm_d = asm_next;
          idx_d = idx_q + 2'd1;
          if (cmd_q == CmdSetCount) begin
            count_d = rx_data;
            if (CrcEn) begin
              state_d    = StTxAck;
              tx_valid_d = 1'b1;
              tx_data_d  = crc_next;
            end else begin
              state_d = StIdle;
            end
          end else if (idx_q == 2'd3) begin
            if (cmd_q == CmdSetAddr) begin
              addr_d      = ADDR_W'(asm_next);
              addr_d[1:0] = 2'b00;
              if (CrcEn) begin
                state_d    = StTxAck;
                tx_valid_d = 1'b1;
                tx_data_d  = crc_next;
              end else begin
                state_d = StIdle;
              end
            end else begin
              state_d = StBusWr;
            end
          end
        end
      end

      StBusWr: begin
        if (rx_valid) overrun_d = 1'b1;
        if (bus_done) begin
          addr_d  = addr_q + ADDR_W'(4);
          words_d = words_q - 8'd1;
          if (words_q == 8'd1) begin
            if (CrcEn) begin
              state_d    = StTxAck;
              tx_valid_d = 1'b1;
              tx_data_d  = crc_q;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StArg;
          end
        end
      end

      StBusRd: begin
        if (rx_valid) overrun_d = 1'b1;
        if (bus_done) begin
          addr_d     = addr_q + ADDR_W'(4);
          words_d    = words_q - 8'd1;
          word_d     = bus_rdata;
          tx_valid_d = 1'b1;
          tx_data_d  = bus_rdata[31:24];
          tx_rem_d   = 2'd3;
          state_d    = StTxWord;
        end
      end

      StTxWord: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          if (tx_rem_q != 2'd0) begin
            word_d    = word_q << 8;
            tx_data_d = word_q[23:16];
            tx_rem_d  = tx_rem_q - 2'd1;
          end else if (cmd_q == CmdAlive) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else if (words_q != 8'd0) begin
            tx_valid_d = 1'b0;
            state_d    = StBusRd;
          end else if (CrcEn) begin
            tx_data_d = crc_next;
            state_d   = StTxAck;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end
        end
      end

      StTxAck: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= 8'h00;
      idx_q      <= 2'd0;
      asm_q      <= 32'h0;
      count_q    <= 8'd1;
      words_q    <= 8'd0;
      addr_q     <= '0;
      word_q     <= 32'h0;
      tx_rem_q   <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      core_rst_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      count_q    <= count_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      tx_rem_q   <= tx_rem_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      core_rst_q <= core_rst_d;
      overrun_q  <= overrun_d;
    end
  end

  // addr_q and asm_q only move outside the bus states, so they are stable while bus_req.
  assign bus_req    = (state_q == StBusWr) || (state_q == StBusRd);
  assign bus_wen    = (state_q == StBusWr);
  assign bus_addr   = addr_q;
  assign bus_wdata  = asm_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign core_rst_o = core_rst_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Directed bench for dbg_cmd_engine: byte-level commands, a simple bus
// responder with programmable latency and a transmit-byte monitor.
module tb_dbg_cmd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_done = 1'b0;
  logic        core_rst_o;
  logic        rx_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          bus_lat = 1;
  int          lat_cnt = 0;

  logic [7:0] exp_rd [8] = '{8'h00, 8'h40, 8'h80, 8'h93, 8'h0F, 8'hF0, 8'h01, 8'h13};

  dbg_cmd_engine dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .bus_req   (bus_req),
    .bus_wen   (bus_wen),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_done  (bus_done),
    .core_rst_o(core_rst_o),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Transmit monitor: a byte leaves on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  // Bus responder: bus_done after bus_lat cycles of bus_req, held across one rising edge.
  always @(negedge clk) begin
    if (rst) begin
      bus_done = 1'b0;
      lat_cnt  = 0;
    end else if (bus_done) begin
      bus_done = 1'b0;
    end else if (bus_req) begin
      lat_cnt++;
      if (lat_cnt >= bus_lat) begin
        lat_cnt  = 0;
        bus_done = 1'b1;
        if (bus_wen) begin
          wr_addr_q.push_back(bus_addr);
          wr_data_q.push_back(bus_wdata);
        end else begin
          bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEADBEEF;
        end
      end
    end
  end

`ifdef DBG_CRC_EN
  function automatic logic [7:0] crc8(logic [7:0] crc, logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input string tag, input int i, input logic [7:0] exp);
    logic [7:0] obs;
    obs = (i < tx_q.size()) ? tx_q[i] : 8'bx;
    check(tag, {24'h0, obs}, {24'h0, exp});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"},  {31'h0, tx_valid},   32'h0);
    check({tag, "_tx_data"},   {24'h0, tx_data},    32'h0);
    check({tag, "_bus_req"},   {31'h0, bus_req},    32'h0);
    check({tag, "_bus_wen"},   {31'h0, bus_wen},    32'h0);
    check({tag, "_bus_addr"},  bus_addr,            32'h0);
    check({tag, "_bus_wdata"}, bus_wdata,           32'h0);
    check({tag, "_core_rst"},  {31'h0, core_rst_o}, 32'h0);
    check({tag, "_overrun"},   {31'h0, rx_overrun}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // SET_COUNT 1
    tx_q.delete();
    send(8'h82); send(8'h01);
    tick(5);
`ifdef DBG_CRC_EN
    check("setcnt_ack_n", tx_q.size(), 1);
    check_tx("setcnt_ack", 0, 8'h07);
`else
    check("setcnt_ack_n", tx_q.size(), 0);
`endif

    // SET_ADDR 0x8400, then one-word WRITE
    tx_q.delete();
    send(8'h83); send(8'h00); send(8'h00); send(8'h84); send(8'h00);
    tick(5);
`ifdef DBG_CRC_EN
    c = crc8(crc8(crc8(crc8(8'h00, 8'h00), 8'h00), 8'h84), 8'h00);
    check("setaddr_ack_n", tx_q.size(), 1);
    check_tx("setaddr_ack", 0, c);
`else
    check("setaddr_ack_n", tx_q.size(), 0);
`endif
    tx_q.delete();
    send(8'h85); send(8'h80); send(8'h00); send(8'h00); send(8'hB7);
    tick(10);
    check("wr1_n", wr_addr_q.size(), 1);
    check("wr1_addr", wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx, 32'h0000_8400);
    check("wr1_data", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h8000_00B7);
`ifdef DBG_CRC_EN
    c = crc8(crc8(crc8(crc8(8'h00, 8'h80), 8'h00), 8'h00), 8'hB7);
    check("wr1_ack", tx_q.size(), 1);
    check_tx("wr1_ack_byte", 0, c);
`endif
    wr_addr_q.delete(); wr_data_q.delete();
    send(8'h85); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    tick(10);
    check("wr2_n", wr_addr_q.size(), 1);
    check("wr2_addr", wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx, 32'h0000_8404);

    // READ two words from 0x8400
    send(8'h82); send(8'h02);
    send(8'h83); send(8'h00); send(8'h00); send(8'h84); send(8'h00);
    tick(5);
    tx_q.delete();
    rd_q.push_back(32'h0040_8093);
    rd_q.push_back(32'h0FF0_0113);
    send(8'h84);
    tick(40);
`ifdef DBG_CRC_EN
    check("rd_n", tx_q.size(), 9);
    c = 8'h00;
    for (int i = 0; i < 8; i++) c = crc8(c, exp_rd[i]);
    check_tx("rd_crc", 8, c);
`else
    check("rd_n", tx_q.size(), 8);
`endif
    for (int i = 0; i < 8; i++) check_tx($sformatf("rd_byte%0d", i), i, exp_rd[i]);
    wr_addr_q.delete(); wr_data_q.delete();
    send(8'h82); send(8'h01);
    send(8'h85); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick(10);
    check("rd_addr_end", wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx, 32'h0000_8408);

    // ALIVE
    tx_q.delete();
    send(8'h86);
    tick(6);
    check("alive_n", tx_q.size(), 2);
    check_tx("alive_b0", 0, 8'h00);
    check_tx("alive_b1", 1, 8'hAE);

    // CORE_RST / CORE_NORM, idempotent repeats
    send(8'h87);
    check("core_rst", {31'h0, core_rst_o}, 32'h1);
    send(8'h87);
    check("core_rst_rep", {31'h0, core_rst_o}, 32'h1);
    send(8'h88);
    check("core_norm", {31'h0, core_rst_o}, 32'h0);

    // Overrun during a slow write (count is 1, addr is 0x840C)
    tx_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    bus_lat = 20;
    send(8'h85); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    tick(3);
    check("ovr_busreq", {30'h0, bus_req, bus_wen}, 32'h3);
    check("ovr_pre", {31'h0, rx_overrun}, 32'h0);
    send(8'h86);
    check("ovr_flag", {31'h0, rx_overrun}, 32'h1);
    tick(30);
    check("ovr_wr_n", wr_addr_q.size(), 1);
    check("ovr_wr_addr", wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx, 32'h0000_840C);
    check("ovr_wr_data", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h1122_3344);
`ifdef DBG_CRC_EN
    c = crc8(crc8(crc8(crc8(8'h00, 8'h11), 8'h22), 8'h33), 8'h44);
    check("ovr_tx_n", tx_q.size(), 1);
    check_tx("ovr_ack", 0, c);
`else
    check("ovr_tx_n", tx_q.size(), 0);
`endif
    bus_lat = 1;

    // Transmit back-pressure
    tx_q.delete();
    tx_ready = 1'b0;
    send(8'h86);
    tick(1);
    check("stall_valid0", {31'h0, tx_valid}, 32'h1);
    check("stall_data0", {24'h0, tx_data}, 32'h00);
    tick(10);
    check("stall_valid1", {31'h0, tx_valid}, 32'h1);
    check("stall_data1", {24'h0, tx_data}, 32'h00);
    tx_ready = 1'b1;
    tick(4);
    check("stall_n", tx_q.size(), 2);
    check_tx("stall_b0", 0, 8'h00);
    check_tx("stall_b1", 1, 8'hAE);

    // Reset mid-WRITE, core held in reset beforehand
    send(8'h87);
    wr_addr_q.delete(); wr_data_q.delete();
    send(8'h85); send(8'hAA); send(8'hBB);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    tx_q.delete();
    tick(1);
    send(8'h86);
    tick(6);
    check("midrst_wr_n", wr_addr_q.size(), 0);
    check("midrst_alive_n", tx_q.size(), 2);
    check_tx("midrst_alive_b0", 0, 8'h00);
    check_tx("midrst_alive_b1", 1, 8'hAE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
